// File: rtl/muxnx1_arb_if.sv
// Bundle of upstream FIFO, downstream FIFO and output-word signals for muxnx1_arb.
// master: arbiter side; slave: the FIFOs/consumer side.
interface muxnx1_arb_if #(
  parameter int DATA_SIZE = 10,
  parameter int NUM_CH    = 4,
  parameter int SEL_W     = 2
);
  logic [NUM_CH-1:0]           fifo_empty;
  logic [NUM_CH*DATA_SIZE-1:0] in;
  logic                        fifo_down_almostfull;
  logic [NUM_CH-1:0]           pop;
  logic [DATA_SIZE-1:0]        out;
  logic                        valid;
  logic [SEL_W-1:0]            sel_ch;

  modport master (
    input  fifo_empty, in, fifo_down_almostfull,
    output pop, out, valid, sel_ch
  );

  modport slave (
    output fifo_empty, in, fifo_down_almostfull,
    input  pop, out, valid, sel_ch
  );
endinterface

// File: rtl/muxnx1_arb.sv
// N:1 packet-word multiplexer: pops one upstream FIFO per cycle and registers the word downstream.
// Round-robin with burst lock (MODE 0) or fixed lowest-index priority (MODE 1).
module muxnx1_arb #(
  parameter int DATA_SIZE = 10,
  parameter int NUM_CH    = 4,
  parameter int SEL_W     = 2,
  parameter int MODE      = 0,
  parameter int MAX_BURST = 1
) (
  input  logic         clk,
  input  logic         reset,
  muxnx1_arb_if.master bus
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [SEL_W-1:0]      owner_q, owner_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DATA_SIZE-1:0]  out_q, out_d;
  logic                  valid_q, valid_d;

  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     pop;
  logic [SEL_W-1:0]      win;
  logic [SEL_W-1:0]      cand;
  logic                  found;
  logic                  grant;

  // Channel index increment that wraps at NUM_CH, which need not be a power of two.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    if (int'(ch) == NUM_CH - 1) return '0;
    return ch + SEL_W'(1);
  endfunction

  always_comb begin
    req   = ~bus.fifo_empty;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    if (MODE == 0 && state_q == BURST && req[owner_q]) begin
      win   = owner_q;
      found = 1'b1;
    end else begin
      cand = (MODE == 0) ? ptr_q : '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[cand]) begin
          win   = cand;
          found = 1'b1;
        end
        cand = next_ch(cand);
      end
    end
    grant = found && !bus.fifo_down_almostfull && reset;
    pop   = '0;
    if (grant) pop[win] = 1'b1;
  end

  // A drained owner ends the burst even when another channel is popped in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    sel_d   = sel_q;
    valid_d = grant;
    if (grant) begin
      out_d = bus.in[int'(win)*DATA_SIZE +: DATA_SIZE];
      sel_d = win;
    end
    if (MODE == 0 && !bus.fifo_down_almostfull) begin
      if (state_q == BURST && !req[owner_q]) begin
        cnt_d = '0;
        ptr_d = next_ch(owner_q);
      end else if (grant) begin
        if (state_q == IDLE || win != owner_q) begin
          owner_d = win;
          if (MAX_BURST == 1) begin
            cnt_d = '0;
            ptr_d = next_ch(win);
          end else begin
            cnt_d = 4'd1;
          end
        end else if (int'(cnt_q) + 1 == MAX_BURST) begin
          cnt_d = '0;
          ptr_d = next_ch(owner_q);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
    state_d = (cnt_d != 4'd0) ? BURST : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pop    = pop;
  assign bus.out    = out_q;
  assign bus.valid  = valid_q;
  assign bus.sel_ch = sel_q;

endmodule

// File: tb/tb_muxnx1_arb.sv
// Directed bench for muxnx1_arb: round-robin (burst 1 and 2), stall, fixed priority and async reset.
module tb_muxnx1_arb;
  localparam int DW = 10;
  localparam int NC = 4;
  localparam int SW = 2;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [DW-1:0] word [NC];

  muxnx1_arb_if #(.DATA_SIZE(DW), .NUM_CH(NC), .SEL_W(SW)) b0 ();
  muxnx1_arb_if #(.DATA_SIZE(DW), .NUM_CH(NC), .SEL_W(SW)) b1 ();
  muxnx1_arb_if #(.DATA_SIZE(DW), .NUM_CH(NC), .SEL_W(SW)) b2 ();

  muxnx1_arb #(.DATA_SIZE(DW), .NUM_CH(NC), .SEL_W(SW), .MODE(0), .MAX_BURST(1))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  muxnx1_arb #(.DATA_SIZE(DW), .NUM_CH(NC), .SEL_W(SW), .MODE(0), .MAX_BURST(2))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  muxnx1_arb #(.DATA_SIZE(DW), .NUM_CH(NC), .SEL_W(SW), .MODE(1), .MAX_BURST(1))
    u2 (.clk(clk), .reset(reset), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    b0.fifo_empty = '1; b1.fifo_empty = '1; b2.fifo_empty = '1;
    b0.fifo_down_almostfull = 1'b0; b1.fifo_down_almostfull = 1'b0; b2.fifo_down_almostfull = 1'b0;
    b0.in = {word[3], word[2], word[1], word[0]};
    b1.in = {word[3], word[2], word[1], word[0]};
    b2.in = '0;
    #2;
    reset = 1'b0;
    b0.fifo_empty = '0; b1.fifo_empty = '0; b2.fifo_empty = '0;
    #1;
    n_checks++;
    if (b0.pop !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_pop0: got %b expected 0000", b0.pop); end
    n_checks++;
    if (b2.pop !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_pop2: got %b expected 0000", b2.pop); end
    n_checks++;
    if (b0.valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", b0.valid); end
    n_checks++;
    if (b0.out !== 10'h000) begin n_fail++; $display("[TB] FAIL reset_out: got %h expected 000", b0.out); end
    n_checks++;
    if (b0.sel_ch !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_sel: got %0d expected 0", b0.sel_ch); end
    @(posedge clk); #1;
    n_checks++;
    if (b1.valid !== 1'b0 || b1.pop !== 4'b0000)
      begin n_fail++; $display("[TB] FAIL reset_held: got valid=%b pop=%b expected 0/0000", b1.valid, b1.pop); end
    b0.fifo_empty = '1; b1.fifo_empty = '1; b2.fifo_empty = '1;
    reset = 1'b1;
  endtask

  // Only ch3 requests from pointer 0; the pointer then wraps to 0.
  task automatic test_wrap();
    b0.fifo_empty = 4'b0111;
    #1;
    n_checks++;
    if (b0.pop !== 4'b1000) begin n_fail++; $display("[TB] FAIL wrap_pop: got %b expected 1000", b0.pop); end
    @(posedge clk); #1;
    n_checks++;
    if (b0.valid !== 1'b1 || b0.sel_ch !== 2'd3 || b0.out !== word[3])
      begin n_fail++; $display("[TB] FAIL wrap_out: got v=%b sel=%0d out=%h expected 1/3/%h", b0.valid, b0.sel_ch, b0.out, word[3]); end
    b0.fifo_empty = 4'b0000;
    #1;
    n_checks++;
    if (b0.pop !== 4'b0001) begin n_fail++; $display("[TB] FAIL wrap_ptr: got %b expected 0001", b0.pop); end
    b0.fifo_empty = '1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop;
    int         exp_ch;
    b0.fifo_empty = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      exp_ch  = i % 4;
      exp_pop = 4'b0001 << exp_ch;
      #1;
      n_checks++;
      if (b0.pop !== exp_pop) begin n_fail++; $display("[TB] FAIL rr_pop[%0d]: got %b expected %b", i, b0.pop, exp_pop); end
      @(posedge clk); #1;
      n_checks++;
      if (b0.valid !== 1'b1 || int'(b0.sel_ch) != exp_ch || b0.out !== word[exp_ch])
        begin n_fail++; $display("[TB] FAIL rr_out[%0d]: got v=%b sel=%0d out=%h expected 1/%0d/%h", i, b0.valid, b0.sel_ch, b0.out, exp_ch, word[exp_ch]); end
    end
    b0.fifo_empty = '1;
    @(posedge clk); #1;
    n_checks++;
    if (b0.valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_idle_valid: got %b expected 0", b0.valid); end
  endtask

  // Ends mid-burst with owner 2 and cnt 1, which test_stall relies on.
  task automatic test_burst();
    int seq_a [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int seq_b [5] = '{0, 0, 1, 2, 2};
    b1.fifo_empty = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (b1.pop !== (4'b0001 << seq_a[i])) begin n_fail++; $display("[TB] FAIL burst_pop[%0d]: got %b expected ch%0d", i, b1.pop, seq_a[i]); end
      @(posedge clk); #1;
      n_checks++;
      if (b1.valid !== 1'b1 || int'(b1.sel_ch) != seq_a[i])
        begin n_fail++; $display("[TB] FAIL burst_sel[%0d]: got v=%b sel=%0d expected 1/%0d", i, b1.valid, b1.sel_ch, seq_a[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (b1.pop !== (4'b0001 << seq_b[i])) begin n_fail++; $display("[TB] FAIL drain_pop[%0d]: got %b expected ch%0d", i, b1.pop, seq_b[i]); end
      @(posedge clk); #1;
      n_checks++;
      if (b1.valid !== 1'b1 || int'(b1.sel_ch) != seq_b[i] || b1.out !== word[seq_b[i]])
        begin n_fail++; $display("[TB] FAIL drain_sel[%0d]: got sel=%0d out=%h expected %0d/%h", i, b1.sel_ch, b1.out, seq_b[i], word[seq_b[i]]); end
      if (i == 2) b1.fifo_empty = 4'b0010;
    end
  endtask

  task automatic test_stall();
    b1.fifo_down_almostfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (b1.pop !== 4'b0000) begin n_fail++; $display("[TB] FAIL stall_pop[%0d]: got %b expected 0000", i, b1.pop); end
      @(posedge clk); #1;
      n_checks++;
      if (b1.valid !== 1'b0 || b1.sel_ch !== 2'd2 || b1.out !== word[2])
        begin n_fail++; $display("[TB] FAIL stall_hold[%0d]: got v=%b sel=%0d out=%h expected 0/2/%h", i, b1.valid, b1.sel_ch, b1.out, word[2]); end
    end
    b1.fifo_down_almostfull = 1'b0;
    #1;
    n_checks++;
    if (b1.pop !== 4'b0100) begin n_fail++; $display("[TB] FAIL stall_release_pop: got %b expected 0100", b1.pop); end
    @(posedge clk); #1;
    n_checks++;
    if (b1.valid !== 1'b1 || b1.sel_ch !== 2'd2) begin n_fail++; $display("[TB] FAIL stall_release_sel: got v=%b sel=%0d expected 1/2", b1.valid, b1.sel_ch); end
    #1;
    n_checks++;
    if (b1.pop !== 4'b1000) begin n_fail++; $display("[TB] FAIL stall_next_pop: got %b expected 1000", b1.pop); end
    @(posedge clk); #1;
    n_checks++;
    if (b1.sel_ch !== 2'd3 || b1.out !== word[3]) begin n_fail++; $display("[TB] FAIL stall_next_out: got sel=%0d out=%h expected 3/%h", b1.sel_ch, b1.out, word[3]); end
  endtask

  task automatic test_reset_mid_burst();
    b1.fifo_empty = 4'b0000;
    reset = 1'b0;
    #1;
    n_checks++;
    if (b1.pop !== 4'b0000 || b1.valid !== 1'b0 || b1.out !== 10'h000 || b1.sel_ch !== 2'd0)
      begin n_fail++; $display("[TB] FAIL midrst_clear: got pop=%b v=%b out=%h sel=%0d expected 0000/0/000/0", b1.pop, b1.valid, b1.out, b1.sel_ch); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (b1.pop !== 4'b0001) begin n_fail++; $display("[TB] FAIL midrst_grant: got %b expected 0001", b1.pop); end
    @(posedge clk); #1;
    n_checks++;
    if (b1.valid !== 1'b1 || b1.sel_ch !== 2'd0 || b1.out !== word[0])
      begin n_fail++; $display("[TB] FAIL midrst_out: got v=%b sel=%0d out=%h expected 1/0/%h", b1.valid, b1.sel_ch, b1.out, word[0]); end
    n_checks++;
    if (b1.pop !== 4'b0001) begin n_fail++; $display("[TB] FAIL midrst_burst: got %b expected 0001", b1.pop); end
    b1.fifo_empty = '1;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_priority();
    b2.in = {10'h0AA, 10'h3FF, 10'h155, 10'h001};
    b2.fifo_empty = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (b2.pop !== 4'b0010) begin n_fail++; $display("[TB] FAIL fp_pop1[%0d]: got %b expected 0010", i, b2.pop); end
      @(posedge clk); #1;
      n_checks++;
      if (b2.valid !== 1'b1 || b2.sel_ch !== 2'd1 || b2.out !== 10'h155)
        begin n_fail++; $display("[TB] FAIL fp_out1[%0d]: got v=%b sel=%0d out=%h expected 1/1/155", i, b2.valid, b2.sel_ch, b2.out); end
    end
    b2.fifo_empty = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (b2.pop !== 4'b1000) begin n_fail++; $display("[TB] FAIL fp_pop3[%0d]: got %b expected 1000", i, b2.pop); end
      @(posedge clk); #1;
      n_checks++;
      if (b2.valid !== 1'b1 || b2.sel_ch !== 2'd3 || b2.out !== 10'h0AA)
        begin n_fail++; $display("[TB] FAIL fp_out3[%0d]: got v=%b sel=%0d out=%h expected 1/3/0aa", i, b2.valid, b2.sel_ch, b2.out); end
    end
    b2.fifo_empty = '1;
    @(posedge clk); #1;
    n_checks++;
    if (b2.valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fp_idle_valid: got %b expected 0", b2.valid); end
  endtask

  initial begin
    word[0] = 10'h100;
    word[1] = 10'h0F1;
    word[2] = 10'h2E2;
    word[3] = 10'h3D3;
    test_reset();
    test_wrap();
    test_round_robin();
    test_burst();
    test_stall();
    test_reset_mid_burst();
    test_fixed_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
